// File: rtl/drawbridge_pkg.sv
// Shared drawbridge definitions: state encodings, on/off levels and the lift output bundle.
package drawbridge_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_WARN     = 3'd1;
   localparam logic [STATE_W-1:0] ST_CLEAR    = 3'd2;
   localparam logic [STATE_W-1:0] ST_RAISING  = 3'd3;
   localparam logic [STATE_W-1:0] ST_UP       = 3'd4;
   localparam logic [STATE_W-1:0] ST_LOWERING = 3'd5;
   localparam logic [STATE_W-1:0] ST_FAULT    = 3'd7;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef struct packed {
      logic motor_up;
      logic motor_down;
      logic barrier;
      logic alert;
      logic bridge_up;
      logic fault;
   } lift_out_t;

   // Counter width for a count range of n, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter with synchronous clear; clear wins over count enable.
module phase_timer #(
   parameter int unsigned W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/bridge_lift_sequencer.sv
// Interlocked bridge lift sequence: warn, close barrier, wait for empty deck, raise,
// hold, lower; motor/limit failures are trapped in FAULT until acknowledged.
module bridge_lift_sequencer
   import drawbridge_pkg::*;
#(
   parameter int unsigned WARN_CYCLES  = 8,
   parameter int unsigned MOVE_TIMEOUT = 64,
   parameter int unsigned BLINK_HALF   = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_open_req,
   input  logic               i_has_car,
   input  logic               i_lim_up,
   input  logic               i_lim_down,
   input  logic               i_fault_clr,
   output logic               o_motor_up,
   output logic               o_motor_down,
   output logic               o_barrier,
   output logic               o_alert,
   output logic               o_bridge_up,
   output logic               o_fault,
   output logic [STATE_W-1:0] o_state
);

   localparam int unsigned TMR_RANGE = (MOVE_TIMEOUT > WARN_CYCLES) ? MOVE_TIMEOUT : WARN_CYCLES;
   localparam int unsigned TMR_W     = cnt_width(TMR_RANGE);
   localparam int unsigned BLK_W     = cnt_width(BLINK_HALF);

   logic [STATE_W-1:0] state_q, state_d;
   logic               blink_q, blink_d;
   lift_out_t          out_q, out_d;
   logic [TMR_W-1:0]   tmr;
   logic [BLK_W-1:0]   blk_cnt;
   logic               tmr_clr_c, blk_clr_c;

   phase_timer #(.W(TMR_W)) u_state_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (tmr_clr_c),
      .i_en    (ON),
      .o_cnt   (tmr)
   );

   phase_timer #(.W(BLK_W)) u_blink_timer (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (blk_clr_c),
      .i_en    (ON),
      .o_cnt   (blk_cnt)
   );

   always_comb begin
      state_d = state_q;
      blink_d = blink_q;
      out_d   = '0;

      if ((state_q != ST_FAULT) && i_lim_up && i_lim_down) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: if (i_open_req) state_d = ST_WARN;
            ST_WARN: begin
               if (!i_open_req) state_d = ST_IDLE;
               else if (tmr == TMR_W'(WARN_CYCLES - 1)) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
               if (!i_open_req) state_d = ST_IDLE;
               else if (!i_has_car) state_d = ST_RAISING;
            end
            ST_RAISING: begin
               if (i_lim_up) state_d = ST_UP;
               else if (!i_open_req) state_d = ST_LOWERING;
               else if (tmr == TMR_W'(MOVE_TIMEOUT - 1)) state_d = ST_FAULT;
            end
            ST_UP: if (!i_open_req) state_d = ST_LOWERING;
            ST_LOWERING: begin
               if (i_lim_down) state_d = ST_IDLE;
               else if (tmr == TMR_W'(MOVE_TIMEOUT - 1)) state_d = ST_FAULT;
            end
            ST_FAULT: if (i_fault_clr && i_lim_down && !i_lim_up) state_d = ST_IDLE;
            default: state_d = ST_FAULT;
         endcase
      end

      // Blink phase is primed to 1 while idle so the first alert cycle is lit.
      if (state_q == ST_IDLE) begin
         blink_d = ON;
      end else if (blk_cnt == BLK_W'(BLINK_HALF - 1)) begin
         blink_d = ~blink_q;
      end

      // Outputs are decoded from the next state so they line up with the registered state.
      case (state_d)
         ST_WARN, ST_CLEAR: begin
            out_d.barrier = ON;
            out_d.alert   = blink_d;
         end
         ST_RAISING: begin
            out_d.barrier  = ON;
            out_d.motor_up = ON;
            out_d.alert    = blink_d;
         end
         ST_UP: begin
            out_d.barrier   = ON;
            out_d.bridge_up = ON;
            out_d.alert     = blink_d;
         end
         ST_LOWERING: begin
            out_d.barrier    = ON;
            out_d.motor_down = ON;
            out_d.alert      = blink_d;
         end
         ST_FAULT: begin
            out_d.barrier = ON;
            out_d.alert   = ON;
            out_d.fault   = ON;
         end
         default: out_d = '0;
      endcase

      tmr_clr_c = (state_d != state_q);
      blk_clr_c = (state_q == ST_IDLE) || (blk_cnt == BLK_W'(BLINK_HALF - 1));
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         blink_q <= OFF;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         blink_q <= blink_d;
         out_q   <= out_d;
      end
   end

   assign o_motor_up   = out_q.motor_up;
   assign o_motor_down = out_q.motor_down;
   assign o_barrier    = out_q.barrier;
   assign o_alert      = out_q.alert;
   assign o_bridge_up  = out_q.bridge_up;
   assign o_fault      = out_q.fault;
   assign o_state      = state_q;

endmodule
